// File: rtl/bitfusion_pkg.sv
// ---------------------------------------------------------------------------
// bitfusion_pkg
// Shared types and constants for the bitfusion job sequencer:
//   state_t       - sequencer FSM states
//   W1/W2/W4      - the legal operand bit-width codes
//   width_legal() - true when a width code is one of W1/W2/W4
//   PSUM_W_DEF / ACC_W_DEF - default datapath psum and accumulator widths
// ---------------------------------------------------------------------------
package bitfusion_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] W1 = 3'd1;
   localparam logic [2:0] W2 = 3'd2;
   localparam logic [2:0] W4 = 3'd4;

   localparam int PSUM_W_DEF = 18;
   localparam int ACC_W_DEF  = 32;

   function automatic logic width_legal(input logic [2:0] w);
      return (w == W1) || (w == W2) || (w == W4);
   endfunction

endpackage

// File: rtl/bitfusion_vld_pipe.sv
// ---------------------------------------------------------------------------
// bitfusion_vld_pipe
// Valid-bit shift register of parameterised depth. A bit entering at head_in
// appears at tail_out DEPTH clock edges later. Cleared by the asynchronous
// reset, so anything in flight is forgotten.
//   clk      - clock, rising edge
//   rst      - asynchronous active-high clear
//   head_in  - valid bit entering the pipe
//   tail_out - valid bit leaving the pipe
// DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module bitfusion_vld_pipe #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic head_in,
   output logic tail_out
);

   logic [DEPTH-1:0] stage_reg;
   logic [DEPTH-1:0] stage_next;

   assign stage_next = {stage_reg[DEPTH-2:0], head_in};

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         always_ff @(posedge clk or posedge rst) begin
            if (rst) stage_reg[gi] <= 1'b0;
            else     stage_reg[gi] <= stage_next[gi];
         end
      end
   endgenerate

   assign tail_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/bitfusion_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bitfusion_seq_ctrl
// Job sequencer for one bitfusion datapath. Accepts a dot-product command,
// streams len operand pairs from the input/weight buffers into the datapath
// (one per cycle, no bubbles), accumulates the returned psums and hands back
// one signed result per job.
//   clk, rst            - clock and asynchronous active-high reset
//   cmd_*               - command handshake and job fields
//   in_rd_*, wt_rd_*    - buffer read ports (data valid one cycle after en)
//   fu_*                - datapath operands/config, fu_psum returned result
//   res_valid/ready     - result handshake; res_data sum, res_err bad width
//   busy                - sequencer not idle
// ---------------------------------------------------------------------------
module bitfusion_seq_ctrl
   import bitfusion_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int LEN_W    = 8,
   parameter int PSUM_W   = PSUM_W_DEF,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int PIPE_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [ADDR_W-1:0] cmd_in_base,
   input  logic [ADDR_W-1:0] cmd_wt_base,
   input  logic [2:0]        cmd_in_width,
   input  logic [2:0]        cmd_wt_width,
   input  logic              cmd_s_in,
   input  logic              cmd_s_wt,
   output logic              in_rd_en,
   output logic [ADDR_W-1:0] in_rd_addr,
   input  logic [3:0]        in_rd_data,
   output logic              wt_rd_en,
   output logic [ADDR_W-1:0] wt_rd_addr,
   input  logic [3:0]        wt_rd_data,
   output logic [3:0]        fu_in,
   output logic [3:0]        fu_weight,
   output logic [2:0]        fu_in_width,
   output logic [2:0]        fu_weight_width,
   output logic              fu_s_in,
   output logic              fu_s_weight,
   input  logic [PSUM_W-1:0] fu_psum,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_err,
   output logic              busy
);

   state_t             state_reg;
   logic [LEN_W-1:0]   len_reg;
   logic [LEN_W-1:0]   k_reg;        // index of the read currently on the bus
   logic [LEN_W-1:0]   acc_cnt_reg;  // psums accumulated so far this job
   logic [ACC_W-1:0]   acc_reg;
   logic               rd_vld_reg;   // buffer data valid this cycle
   logic               psum_vld;
   logic [ACC_W-1:0]   psum_ext;

   // A read issued in cycle t lands in fu_* at t+2 and its psum is valid
   // PIPE_LAT cycles after that, so the tracker is 2+PIPE_LAT deep.
   bitfusion_vld_pipe #(
      .DEPTH (2 + PIPE_LAT)
   ) u_vld_pipe (
      .clk      (clk),
      .rst      (rst),
      .head_in  (in_rd_en),
      .tail_out (psum_vld)
   );

   assign psum_ext = {{(ACC_W-PSUM_W){fu_psum[PSUM_W-1]}}, fu_psum};
   assign busy     = (state_reg != ST_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         len_reg         <= '0;
         k_reg           <= '0;
         acc_cnt_reg     <= '0;
         acc_reg         <= '0;
         rd_vld_reg      <= 1'b0;
         cmd_ready       <= 1'b0;
         in_rd_en        <= 1'b0;
         in_rd_addr      <= '0;
         wt_rd_en        <= 1'b0;
         wt_rd_addr      <= '0;
         fu_in           <= '0;
         fu_weight       <= '0;
         fu_in_width     <= '0;
         fu_weight_width <= '0;
         fu_s_in         <= 1'b0;
         fu_s_weight     <= 1'b0;
         res_valid       <= 1'b0;
         res_data        <= '0;
         res_err         <= 1'b0;
      end else begin
         // Operand staging: capture buffer data on the cycle it is valid.
         rd_vld_reg <= in_rd_en;
         if (rd_vld_reg) begin
            fu_in     <= in_rd_data;
            fu_weight <= wt_rd_data;
         end

         if (psum_vld) begin
            acc_reg     <= acc_reg + psum_ext;
            acc_cnt_reg <= acc_cnt_reg + LEN_W'(1);
         end

         case (state_reg)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready       <= 1'b0;
                  len_reg         <= cmd_len;
                  k_reg           <= '0;
                  acc_reg         <= '0;
                  acc_cnt_reg     <= '0;
                  fu_in_width     <= cmd_in_width;
                  fu_weight_width <= cmd_wt_width;
                  fu_s_in         <= cmd_s_in;
                  fu_s_weight     <= cmd_s_wt;
                  res_err         <= !(width_legal(cmd_in_width) && width_legal(cmd_wt_width));
                  // The first read goes out on the cycle right after acceptance.
                  in_rd_addr      <= cmd_in_base;
                  wt_rd_addr      <= cmd_wt_base;
                  if (cmd_len != '0) begin
                     in_rd_en  <= 1'b1;
                     wt_rd_en  <= 1'b1;
                     state_reg <= ST_ISSUE;
                  end else begin
                     state_reg <= ST_DONE;
                  end
               end
            end

            ST_ISSUE: begin
               if (k_reg == len_reg - LEN_W'(1)) begin
                  in_rd_en  <= 1'b0;
                  wt_rd_en  <= 1'b0;
                  state_reg <= ST_DRAIN;
               end else begin
                  k_reg      <= k_reg + LEN_W'(1);
                  in_rd_addr <= in_rd_addr + ADDR_W'(1);
                  wt_rd_addr <= wt_rd_addr + ADDR_W'(1);
               end
            end

            ST_DRAIN: begin
               if (psum_vld && (acc_cnt_reg == len_reg - LEN_W'(1))) state_reg <= ST_DONE;
            end

            ST_DONE: begin
               if (!res_valid) begin
                  res_valid <= 1'b1;
                  res_data  <= acc_reg;
               end else if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitfusion_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bitfusion_seq_ctrl
// Bench for bitfusion_seq_ctrl: behavioural buffers and a product-based
// datapath model feed the DUT; each job's result is compared with a plain
// arithmetic dot product over the buffer contents.
// ---------------------------------------------------------------------------
module tb_bitfusion_seq_ctrl;

   localparam int PIPE_LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_len;
   logic [7:0]  cmd_in_base;
   logic [7:0]  cmd_wt_base;
   logic [2:0]  cmd_in_width;
   logic [2:0]  cmd_wt_width;
   logic        cmd_s_in;
   logic        cmd_s_wt;
   logic        in_rd_en;
   logic [7:0]  in_rd_addr;
   logic [3:0]  in_rd_data = '0;
   logic        wt_rd_en;
   logic [7:0]  wt_rd_addr;
   logic [3:0]  wt_rd_data = '0;
   logic [3:0]  fu_in;
   logic [3:0]  fu_weight;
   logic [2:0]  fu_in_width;
   logic [2:0]  fu_weight_width;
   logic        fu_s_in;
   logic        fu_s_weight;
   logic [17:0] fu_psum = '0;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        res_err;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic [3:0]  in_mem [256];
   logic [3:0]  wt_mem [256];
   logic [17:0] prod_d1 = '0;

   int in_q[$];
   int wt_q[$];
   int cyc_q[$];

   bitfusion_seq_ctrl #(
      .ADDR_W(8), .LEN_W(8), .PSUM_W(18), .ACC_W(32), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
      .cmd_in_base(cmd_in_base), .cmd_wt_base(cmd_wt_base),
      .cmd_in_width(cmd_in_width), .cmd_wt_width(cmd_wt_width),
      .cmd_s_in(cmd_s_in), .cmd_s_wt(cmd_s_wt),
      .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_rd_data(in_rd_data),
      .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
      .fu_in(fu_in), .fu_weight(fu_weight),
      .fu_in_width(fu_in_width), .fu_weight_width(fu_weight_width),
      .fu_s_in(fu_s_in), .fu_s_weight(fu_s_weight), .fu_psum(fu_psum),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int opval(input logic [3:0] v, input logic s);
      int r;
      r = int'(v);
      if (s && v[3]) r = r - 16;
      return r;
   endfunction

   // Buffers: data valid one cycle after the read strobe.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_rd_en) in_rd_data <= in_mem[in_rd_addr];
      if (wt_rd_en) wt_rd_data <= wt_mem[wt_rd_addr];
   end

   // Datapath: psum is the operand product, PIPE_LAT cycles after fu_* change.
   always @(posedge clk) begin
      prod_d1 <= 18'(opval(fu_in, fu_s_in) * opval(fu_weight, fu_s_weight));
      fu_psum <= prod_d1;
   end

   // Read-port monitor.
   always @(negedge clk) begin
      if (in_rd_en) begin
         in_q.push_back(int'(in_rd_addr));
         cyc_q.push_back(cyc);
      end
      if (wt_rd_en) wt_q.push_back(int'(wt_rd_addr));
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] model_sum(input int len, input int ib, input int wb,
                                             input logic si, input logic sw);
      int s;
      s = 0;
      for (int k = 0; k < len; k++)
         s += opval(in_mem[(ib + k) % 256], si) * opval(wt_mem[(wb + k) % 256], sw);
      return 32'(s);
   endfunction

   function automatic logic legal_code(input logic [2:0] w);
      return (w == 3'd1) || (w == 3'd2) || (w == 3'd4);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 64'({cmd_ready, in_rd_en, in_rd_addr, wt_rd_en, wt_rd_addr,
                                fu_in, fu_weight, fu_in_width, fu_weight_width,
                                fu_s_in, fu_s_weight, res_valid, res_err, busy}), 64'd0);
      check({tag, "_data"}, 64'(res_data), 64'd0);
   endtask

   task automatic run_job(input int len, input int ib, input int wb,
                          input logic [2:0] iw, input logic [2:0] ww,
                          input logic si, input logic sw, input int hold);
      int          n;
      logic [31:0] exp_sum;
      logic        exp_err;
      logic        ok;
      exp_sum = model_sum(len, ib, wb, si, sw);
      exp_err = !(legal_code(iw) && legal_code(ww));
      in_q.delete(); wt_q.delete(); cyc_q.delete();
      cmd_len = 8'(len); cmd_in_base = 8'(ib); cmd_wt_base = 8'(wb);
      cmd_in_width = iw; cmd_wt_width = ww; cmd_s_in = si; cmd_s_wt = sw;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin tick(); n++; end
      if (!cmd_ready) begin
         check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
         cmd_valid = 1'b0;
         return;
      end
      tick();  // acceptance edge
      cmd_valid = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!res_valid && n < 300);
      if (!res_valid) begin
         check("res_timeout", 64'(res_valid), 64'd1);
         return;
      end
      if (len > 0) check("latency", 64'(n), 64'(len + 3 + PIPE_LAT));
      else         check("latency_len0", 64'(n <= 2), 64'd1);
      check("in_rd_count", 64'(in_q.size()), 64'(len));
      check("wt_rd_count", 64'(wt_q.size()), 64'(len));
      ok = (in_q.size() == len) && (wt_q.size() == len);
      if (ok) begin
         for (int k = 0; k < len; k++)
            if (in_q[k] != (ib + k) % 256 || wt_q[k] != (wb + k) % 256) ok = 1'b0;
         if (len > 0 && cyc_q[len-1] - cyc_q[0] != len - 1) ok = 1'b0;
      end
      check("rd_addr_seq", 64'(ok), 64'd1);
      check("res_data", 64'(res_data), 64'(exp_sum));
      check("res_err", 64'(res_err), 64'(exp_err));
      check("fu_cfg", 64'({fu_in_width, fu_weight_width, fu_s_in, fu_s_weight}),
            64'({iw, ww, si, sw}));
      check("busy_done", 64'(busy), 64'd1);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 64'(res_valid), 64'd1);
         check("hold_data", 64'(res_data), 64'(exp_sum));
         check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("res_valid_clear", 64'(res_valid), 64'd0);
      check("busy_idle", 64'(busy), 64'd0);
      $display("job len=%0d in_base=%0d wt_base=%0d iw=%0d ww=%0d s=%0d%0d res=%08h exp=%08h err=%0d lat=%0d",
               len, ib, wb, iw, ww, si, sw, res_data, exp_sum, res_err, n);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      logic seen;
      rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_len = '0; cmd_in_base = '0; cmd_wt_base = '0;
      cmd_in_width = '0; cmd_wt_width = '0; cmd_s_in = 1'b0; cmd_s_wt = 1'b0;
      for (int i = 0; i < 256; i++) begin
         in_mem[i] = 4'($urandom);
         wt_mem[i] = 4'($urandom);
      end
      tick(); tick();
      check_all_zero("reset_state");
      rst = 1'b0;
      tick();
      check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

      // Basic unsigned dot product.
      in_mem[0] = 4'd1; in_mem[1] = 4'd2; in_mem[2] = 4'd3; in_mem[3] = 4'd4;
      wt_mem[0] = 4'd5; wt_mem[1] = 4'd6; wt_mem[2] = 4'd7; wt_mem[3] = 4'd8;
      run_job(4, 0, 0, 3'd4, 3'd4, 1'b0, 1'b0, 0);

      // Signed: -1 * 2.
      in_mem[20] = 4'hF; wt_mem[30] = 4'h2;
      run_job(1, 20, 30, 3'd4, 3'd4, 1'b1, 1'b1, 1);

      // Empty job.
      run_job(0, 77, 99, 3'd2, 3'd1, 1'b0, 1'b0, 1);

      // Address wrap on the input buffer.
      run_job(4, 254, 10, 3'd2, 3'd2, 1'b1, 1'b0, 0);

      // Long hold on the result, then an illegal width code.
      run_job(3, 100, 150, 3'd4, 3'd4, 1'b0, 1'b1, 5);
      run_job(3, 60, 61, 3'd3, 3'd4, 1'b0, 1'b0, 0);

      // Reset during the second ISSUE cycle of a len=8 job.
      cmd_len = 8'd8; cmd_in_base = 8'd40; cmd_wt_base = 8'd80;
      cmd_in_width = 3'd4; cmd_wt_width = 3'd4; cmd_s_in = 1'b0; cmd_s_wt = 1'b0;
      cmd_valid = 1'b1;
      tick();  // acceptance edge (cmd_ready already high)
      cmd_valid = 1'b0;
      tick();  // now in the second ISSUE cycle
      rst = 1'b1;
      #1;
      check_all_zero("abort_reset");
      tick();
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (res_valid) seen = 1'b1;
      end
      check("no_result_after_abort", 64'(seen), 64'd0);
      run_job(2, 5, 6, 3'd4, 3'd4, 1'b1, 1'b1, 0);

      // Randomized jobs.
      for (int j = 0; j < 25; j++) begin
         logic [2:0] iw, ww;
         iw = ($urandom_range(0, 5) == 0) ? 3'($urandom) : (3'd1 << $urandom_range(0, 2));
         ww = ($urandom_range(0, 5) == 0) ? 3'($urandom) : (3'd1 << $urandom_range(0, 2));
         run_job(int'($urandom_range(0, 12)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), iw, ww,
                 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
